// File: rtl/barrel_flow.sv
`default_nettype none
// ============================================================================
//  Module   : barrel_flow
//  Purpose  : Valid/ready flow-control shell around the `barrel` right-shift
//             stage. The shell accepts shift requests, drives the barrel
//             inputs, and captures the barrel output after a fixed latency
//             into a small result FIFO. A request is admitted only when a
//             FIFO slot is guaranteed for it, so consumer backpressure never
//             drops or duplicates a result.
//  Ports    : clk, rst (async, active-high)
//             s_valid/s_ready, s_is_signed, s_shift, s_in, s_ex : requests
//             b_enable, b_is_signed, b_shift, b_in, b_ex         : to barrel
//             b_out                                              : from barrel
//             m_valid/m_ready, m_data                            : results
//             range_err                                          : sticky flag
//  Config   : BARREL_FLOW_CLAMP_EN - clamp shifts above SHIFT_MAX+1 to
//             SHIFT_MAX+1 (result = s_ex) and raise sticky range_err.
//             Undefined: b_shift passes through, range_err tied to 0.
//  Revision : 1.0 - initial release
// ============================================================================
module barrel_flow #(
  parameter int WIDTH       = 64,
  parameter int SHIFT_MAX   = 46,
  parameter int SHIFT_WIDTH = $clog2(SHIFT_MAX + 2),
  parameter int LATENCY     = 2,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  // request side
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic                   s_is_signed,
  input  logic [SHIFT_WIDTH-1:0] s_shift,
  input  logic [WIDTH-1:0]       s_in,
  input  logic [WIDTH-1:0]       s_ex,
  // barrel side
  output logic                   b_enable,
  output logic                   b_is_signed,
  output logic [SHIFT_WIDTH-1:0] b_shift,
  output logic [WIDTH-1:0]       b_in,
  output logic [WIDTH-1:0]       b_ex,
  input  logic [WIDTH-1:0]       b_out,
  // result side
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [WIDTH-1:0]       m_data,
  output logic                   range_err
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  // one extra bit so fifo_count + inflight can never wrap
  localparam int OCC_W = CNT_W + 1;

  logic                   run_q;
  logic [LATENCY-1:0]     valid_q;
  logic [LATENCY-1:0]     valid_d;
  logic [CNT_W-1:0]       count_q;
  logic [CNT_W-1:0]       count_d;
  logic [PTR_W-1:0]       wr_ptr_q;
  logic [PTR_W-1:0]       wr_ptr_d;
  logic [PTR_W-1:0]       rd_ptr_q;
  logic [PTR_W-1:0]       rd_ptr_d;
  logic [WIDTH-1:0]       mem_q [FIFO_DEPTH];

  logic                   w_accept;
  logic                   w_push;
  logic                   w_pop;
  logic [OCC_W-1:0]       w_inflight;
  logic [OCC_W-1:0]       w_occupancy;

  // --------------------------------------------------------------------------
  // Run flag: low throughout reset, high from the first edge after release.
  // It gates both the barrel enable and request acceptance.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run_q <= 1'b0;
    end else begin
      run_q <= 1'b1;
    end
  end

  assign b_enable    = run_q;
  assign b_is_signed = s_is_signed;
  assign b_in        = s_in;
  assign b_ex        = s_ex;

  assign w_accept = s_valid & s_ready;

  // --------------------------------------------------------------------------
  // Valid pipe: tracks which barrel output cycles carry real results.
  // --------------------------------------------------------------------------
  generate
    if (LATENCY == 1) begin : g_vpipe_lat1
      assign valid_d = w_accept;
    end else begin : g_vpipe_latn
      assign valid_d = {valid_q[LATENCY-2:0], w_accept};
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
    end else begin
      valid_q <= valid_d;
    end
  end

  // Credit: every set valid bit already owns a FIFO slot.
  always_comb begin
    w_inflight = '0;
    for (int i = 0; i < LATENCY; i++) begin
      w_inflight = w_inflight + OCC_W'(valid_q[i]);
    end
  end

  // Pop is deliberately ignored here: a slot freed this cycle is only
  // offered next cycle, so a push can never land on a full FIFO.
  assign w_occupancy = OCC_W'(count_q) + w_inflight;
  assign s_ready     = run_q & (w_occupancy < OCC_W'(FIFO_DEPTH));

  // --------------------------------------------------------------------------
  // Result FIFO
  // --------------------------------------------------------------------------
  assign w_push  = valid_q[LATENCY-1];
  assign m_valid = (count_q != '0);
  assign w_pop   = m_valid & m_ready;

  always_comb begin
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (w_push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (w_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({w_push, w_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset: an entry is only read after it was written.
  always_ff @(posedge clk) begin
    if (w_push) begin
      mem_q[wr_ptr_q] <= b_out;
    end
  end

  // Forced to zero when empty so stale storage never shows on the port.
  assign m_data = m_valid ? mem_q[rd_ptr_q] : '0;

  // --------------------------------------------------------------------------
  // Shift clamping
  // --------------------------------------------------------------------------
`ifdef BARREL_FLOW_CLAMP_EN
  localparam logic [SHIFT_WIDTH-1:0] C_EX_SHIFT = SHIFT_WIDTH'(SHIFT_MAX + 1);

  logic w_over;
  logic range_err_q;

  assign w_over  = (s_shift > C_EX_SHIFT);
  assign b_shift = w_over ? C_EX_SHIFT : s_shift;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      range_err_q <= 1'b0;
    end else if (w_accept & w_over) begin
      range_err_q <= 1'b1;
    end
  end

  assign range_err = range_err_q;
`else
  assign b_shift   = s_shift;
  assign range_err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_barrel_flow.sv
`default_nettype none
// ============================================================================
//  Module   : tb_barrel_flow
//  Purpose  : Scoreboard bench for barrel_flow. Emulates the external barrel
//             with a LATENCY-deep register pipe, predicts each accepted
//             request with an arithmetic reference model, and checks the
//             result stream in order from an independent monitor.
//  Config   : BARREL_FLOW_CLAMP_EN - enables the clamp checks.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_barrel_flow;

  localparam int WIDTH      = 64;
  localparam int SHIFT_MAX  = 46;
  localparam int SW         = $clog2(SHIFT_MAX + 2);
  localparam int LATENCY    = 2;
  localparam int FIFO_DEPTH = 4;
`ifdef BARREL_FLOW_CLAMP_EN
  localparam bit CLAMP = 1'b1;
`else
  localparam bit CLAMP = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             s_valid = 1'b0;
  logic             s_ready;
  logic             s_is_signed = 1'b0;
  logic [SW-1:0]    s_shift = '0;
  logic [WIDTH-1:0] s_in = '0;
  logic [WIDTH-1:0] s_ex = '0;
  logic             b_enable;
  logic             b_is_signed;
  logic [SW-1:0]    b_shift;
  logic [WIDTH-1:0] b_in;
  logic [WIDTH-1:0] b_ex;
  logic [WIDTH-1:0] b_out;
  logic             m_valid;
  logic             m_ready = 1'b1;
  logic [WIDTH-1:0] m_data;
  logic             range_err;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  bit exact_mode = 1'b0;
  bit rand_rdy   = 1'b0;

  typedef struct {
    logic [WIDTH-1:0] data;
    int               cyc;
    bit               exact;
  } exp_t;
  exp_t exp_q[$];

  barrel_flow #(
    .WIDTH      (WIDTH),
    .SHIFT_MAX  (SHIFT_MAX),
    .SHIFT_WIDTH(SW),
    .LATENCY    (LATENCY),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_is_signed(s_is_signed),
    .s_shift    (s_shift),
    .s_in       (s_in),
    .s_ex       (s_ex),
    .b_enable   (b_enable),
    .b_is_signed(b_is_signed),
    .b_shift    (b_shift),
    .b_in       (b_in),
    .b_ex       (b_ex),
    .b_out      (b_out),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .range_err  (range_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- barrel emulation (fixed LATENCY) ----------------
  function automatic logic [WIDTH-1:0] barrel_fn(logic sg, logic [SW-1:0] sh,
                                                  logic [WIDTH-1:0] din,
                                                  logic [WIDTH-1:0] ex);
    if (int'(sh) == SHIFT_MAX + 1) return ex;
    if (sg) return WIDTH'($signed(din) >>> sh);
    return din >> sh;
  endfunction

  logic [WIDTH-1:0] bpipe [LATENCY];
  always @(posedge clk) begin
    if (b_enable) begin
      bpipe[0] <= barrel_fn(b_is_signed, b_shift, b_in, b_ex);
      for (int i = 1; i < LATENCY; i++) bpipe[i] <= bpipe[i-1];
    end
  end
  assign b_out = bpipe[LATENCY-1];

  // ---------------- reference model ----------------
  function automatic logic [WIDTH-1:0] ref_model(bit sg, int sh,
                                                  logic [WIDTH-1:0] din,
                                                  logic [WIDTH-1:0] ex);
    logic [WIDTH-1:0] ones;
    logic [WIDTH-1:0] res;
    if (sh == SHIFT_MAX + 1) return ex;
    if (sh > SHIFT_MAX + 1) return CLAMP ? ex : '0;
    ones = '1;
    res  = din >> sh;
    if (sg && din[WIDTH-1]) res = res | ~(ones >> sh);
    return res;
  endfunction

  task automatic chk(string name, logic [WIDTH-1:0] act, logic [WIDTH-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h required %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- request tap: pushes expectations ----------------
  always @(negedge clk) begin
    if (!rst && s_valid && s_ready) begin
      exp_q.push_back('{ref_model(s_is_signed, int'(s_shift), s_in, s_ex),
                        cyc, exact_mode});
      tests++;
      if (exp_q.size() > FIFO_DEPTH) begin
        fails++;
        $display("FAIL occupancy: got %0d outstanding required <= %0d",
                 exp_q.size(), FIFO_DEPTH);
      end
    end
  end

  // ---------------- monitor: pops and compares ----------------
  bit               prev_stall = 1'b0;
  logic [WIDTH-1:0] prev_data  = '0;
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && m_valid) chk("m_data_stable", m_data, prev_data);
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_output: got %h required no output", m_data);
        end else begin
          e = exp_q.pop_front();
          chk("m_data", m_data, e.data);
          if (e.exact) chk("latency", WIDTH'(cyc - e.cyc), WIDTH'(LATENCY + 1));
        end
      end
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
    end
  end

  // ---------------- driver ----------------
  // All driver tasks start and end at posedge+1.
  task automatic send(bit sg, logic [SW-1:0] sh, logic [WIDTH-1:0] din,
                      logic [WIDTH-1:0] ex);
    bit done = 1'b0;
    int waited = 0;
    s_valid = 1'b1; s_is_signed = sg; s_shift = sh; s_in = din; s_ex = ex;
    while (!done) begin
      @(negedge clk);
      done = s_ready;
      @(posedge clk); #1;
      if (rand_rdy) m_ready = 1'($urandom_range(0, 1));
      waited++;
      if (!done && waited > 200) begin
        tests++;
        fails++;
        $display("FAIL accept_timeout: got no accept required accept within 200 cycles");
        done = 1'b1;
      end
    end
  endtask

  task automatic idle(int n);
    s_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [WIDTH-1:0] rnd64();
    return {$urandom(), $urandom()};
  endfunction

  function automatic logic [SW-1:0] rnd_shift();
    return CLAMP ? SW'($urandom_range(0, (1 << SW) - 1))
                 : SW'($urandom_range(0, SHIFT_MAX + 1));
  endfunction

  initial begin
    int acc;
    #2 rst = 1'b1;
    // reset state
    @(negedge clk);
    chk("rst_s_ready",   s_ready,   0);
    chk("rst_m_valid",   m_valid,   0);
    chk("rst_m_data",    m_data,    0);
    chk("rst_b_enable",  b_enable,  0);
    chk("rst_range_err", range_err, 0);
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("post_rst_s_ready",  s_ready,  1);
    chk("post_rst_b_enable", b_enable, 1);
    @(posedge clk); #1;

    // directed, isolated requests with exact latency check
    m_ready = 1'b1;
    exact_mode = 1'b1;
    send(1'b1, SW'(4), 64'h8000_0000_0000_0000, '0);  idle(6);
    exact_mode = 1'b1;
    send(1'b0, SW'(4), 64'h8000_0000_0000_0000, '0);  idle(6);
    exact_mode = 1'b1;
    send(1'b1, SW'(SHIFT_MAX + 1), rnd64(), 64'h1234); idle(6);
    exact_mode = 1'b1;
    send(1'b1, SW'(0), 64'hF0E1_D2C3_B4A5_9687, rnd64()); idle(6);
    exact_mode = 1'b0;

    // backpressure: exactly FIFO_DEPTH accepts
    m_ready = 1'b0;
    s_valid = 1'b1; s_is_signed = 1'b1; s_shift = rnd_shift(); s_in = rnd64(); s_ex = rnd64();
    acc = 0;
    repeat (10) begin
      @(negedge clk);
      if (s_ready) acc++;
      @(posedge clk); #1;
      s_is_signed = 1'($urandom_range(0, 1)); s_shift = rnd_shift();
      s_in = rnd64(); s_ex = rnd64();
    end
    s_valid = 1'b0;
    chk("bp_accepts", WIDTH'(acc), WIDTH'(FIFO_DEPTH));
    @(negedge clk);
    chk("bp_s_ready_low", s_ready, 0);
    @(posedge clk); #1 m_ready = 1'b1;
    @(negedge clk);
    chk("s_ready_during_pop", s_ready, 0);
    @(posedge clk); #1 m_ready = 1'b0;
    @(negedge clk);
    chk("s_ready_after_pop", s_ready, 1);
    @(posedge clk); #1 m_ready = 1'b1;
    idle(8);
    for (int i = 0; i < 4; i++) send(1'($urandom_range(0, 1)), rnd_shift(), rnd64(), rnd64());
    idle(8);

    // random back-to-back with random consumer stalls
    rand_rdy = 1'b1;
    for (int i = 0; i < 100; i++) send(1'($urandom_range(0, 1)), rnd_shift(), rnd64(), rnd64());
    rand_rdy = 1'b0;
    m_ready  = 1'b1;
    idle(12);
    chk("random_drained", WIDTH'(exp_q.size()), 0);

    // reset in the middle of operation
    send(1'b0, SW'(3), rnd64(), rnd64());
    send(1'b1, SW'(5), rnd64(), rnd64());
    s_valid = 1'b0;
    rst = 1'b1;
    exp_q.delete();
    repeat (3) begin
      @(negedge clk);
      chk("midrst_m_valid",  m_valid,  0);
      chk("midrst_s_ready",  s_ready,  0);
      chk("midrst_b_enable", b_enable, 0);
    end
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("midrst_after_s_ready",   s_ready,   1);
    chk("midrst_after_range_err", range_err, 0);
    @(posedge clk); #1;
    idle(10);
    send(1'b1, SW'(12), rnd64(), rnd64());
    idle(6);

`ifdef BARREL_FLOW_CLAMP_EN
    send(1'b1, SW'(60), 64'h8000_0000_0000_0000, 64'h0BAD_CAFE_0000_5A5A);
    idle(10);
    chk("clamp_range_err", range_err, 1);
`else
    chk("noclamp_range_err", range_err, 0);
`endif

    idle(10);
    chk("final_drained", WIDTH'(exp_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
